mano_io_unit: RTL and testbench

//  Input/output and interrupt front-end for the Mano basic computer core. Holds INPR/FGI fed

---
 rtl/mano_io_unit.sv | 160 ++++++++++++++++
 tb/tb_mano_io_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mano_io_unit.sv
// rtl/mano_io_unit.sv - Mano basic computer I/O front-end: INPR/FGI via RX FIFO, OUTR/FGO sender, IEN and R.
module mano_io_unit #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_inp,
  input  logic       io_out,
  input  logic [7:0] out_data,
  input  logic       io_ion,
  input  logic       io_iof,
  input  logic       int_ack,
  input  logic       fetch_busy,
  output logic [7:0] inpr,
  output logic       fgi,
  output logic       fgo,
  output logic       ien,
  output logic       irq,
  output logic       out_drop,
  input  logic [7:0] dev_rx_data,
  input  logic       dev_rx_valid,
  output logic       dev_rx_ready,
  output logic [7:0] dev_tx_data,
  output logic       dev_tx_valid,
  input  logic       dev_tx_ready
);
  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RX_DEPTH);

  typedef enum logic {S_IDLE, S_SEND} tx_state_e;

  logic [7:0]       r_fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_inpr;
  logic             r_fgi;
  logic             r_fgo;
  logic             r_ien;
  logic             r_irq;
  logic             r_out_drop;
  logic [7:0]       r_outr;
  tx_state_e        r_tx_state;

  tx_state_e        w_tx_next;
  logic             w_load_outr;
  logic             w_tx_done;
  logic             w_push;
  logic             w_pop;
  logic             w_not_full;
  logic             w_not_empty;

  assign w_not_full  = (r_count != FULL_CNT);
  assign w_not_empty = (r_count != '0);
  assign w_push      = dev_rx_valid & w_not_full;
  // INPR refills only while FGI is clear, so a pop never coincides with io_inp taking a char
  assign w_pop       = ~r_fgi & w_not_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= dev_rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inpr <= '0;
      r_fgi  <= 1'b0;
    end else if (w_pop) begin
      r_inpr <= r_fifo_mem[r_rd_ptr];
      r_fgi  <= 1'b1;
    end else if (io_inp && r_fgi) begin
      r_fgi  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next   = r_tx_state;
    w_load_outr = 1'b0;
    w_tx_done   = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (io_out && r_fgo) begin
          w_load_outr = 1'b1;
          w_tx_next   = S_SEND;
        end
      end
      S_SEND: begin
        if (dev_tx_ready) begin
          w_tx_done = 1'b1;
          w_tx_next = S_IDLE;
        end
      end
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outr     <= '0;
      r_fgo      <= 1'b1;
      r_out_drop <= 1'b0;
    end else begin
      if (w_load_outr) begin
        r_outr <= out_data;
        r_fgo  <= 1'b0;
      end else if (w_tx_done) begin
        r_fgo  <= 1'b1;
      end
      if (io_out && !r_fgo) r_out_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (int_ack)     r_ien <= 1'b0;
      else if (io_iof) r_ien <= 1'b0;
      else if (io_ion) r_ien <= 1'b1;
      // R is sticky until acknowledged, independent of later flag changes
      if (int_ack)
        r_irq <= 1'b0;
      else if (r_ien && (r_fgi || r_fgo) && !fetch_busy)
        r_irq <= 1'b1;
    end
  end

  assign inpr         = r_inpr;
  assign fgi          = r_fgi;
  assign fgo          = r_fgo;
  assign ien          = r_ien;
  assign irq          = r_irq;
  assign out_drop     = r_out_drop;
  assign dev_rx_ready = w_not_full;
  assign dev_tx_data  = r_outr;
  assign dev_tx_valid = (r_tx_state == S_SEND);
endmodule

// File: tb/tb_mano_io_unit.sv
// tb/tb_mano_io_unit.sv - Directed self-checking bench for mano_io_unit.
module tb_mano_io_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_inp = 1'b0;
  logic       io_out = 1'b0;
  logic [7:0] out_data = '0;
  logic       io_ion = 1'b0;
  logic       io_iof = 1'b0;
  logic       int_ack = 1'b0;
  logic       fetch_busy = 1'b0;
  logic [7:0] inpr;
  logic       fgi, fgo, ien, irq, out_drop;
  logic [7:0] dev_rx_data = '0;
  logic       dev_rx_valid = 1'b0;
  logic       dev_rx_ready;
  logic [7:0] dev_tx_data;
  logic       dev_tx_valid;
  logic       dev_tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mano_io_unit #(.RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .io_inp(io_inp), .io_out(io_out), .out_data(out_data),
    .io_ion(io_ion), .io_iof(io_iof), .int_ack(int_ack), .fetch_busy(fetch_busy),
    .inpr(inpr), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq), .out_drop(out_drop),
    .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
    .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a device character accepted on this edge is withdrawn afterwards.
  task automatic tick();
    logic acc;
    acc = dev_rx_valid && dev_rx_ready;
    @(posedge clk);
    #1;
    if (acc) dev_rx_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_inpr", inpr, 8'h00);
    check("rst_fgi", {7'd0, fgi}, 8'd0);
    check("rst_fgo", {7'd0, fgo}, 8'd1);
    check("rst_ien", {7'd0, ien}, 8'd0);
    check("rst_irq", {7'd0, irq}, 8'd0);
    check("rst_txv", {7'd0, dev_tx_valid}, 8'd0);
    check("rst_rxr", {7'd0, dev_rx_ready}, 8'd1);

    dev_rx_data = 8'h41; dev_rx_valid = 1'b1;
    tick();
    check("rx1_fgi_e1", {7'd0, fgi}, 8'd0);
    tick();
    check("rx1_fgi_e2", {7'd0, fgi}, 8'd1);
    check("rx1_inpr", inpr, 8'h41);
    io_inp = 1'b1; tick(); io_inp = 1'b0;
    check("rx1_inp_fgi", {7'd0, fgi}, 8'd0);
    io_inp = 1'b1; tick(); io_inp = 1'b0;
    check("rx1_inp_nofx", {7'd0, fgi}, 8'd0);

    for (int k = 1; k <= 5; k++) begin
      dev_rx_data = 8'(k); dev_rx_valid = 1'b1;
      tick();
    end
    dev_rx_data = 8'd6; dev_rx_valid = 1'b1;
    tick(); tick();
    check("full_rxr", {7'd0, dev_rx_ready}, 8'd0);
    check("full_inpr", inpr, 8'd1);
    check("full_fgi", {7'd0, fgi}, 8'd1);
    for (int k = 2; k <= 6; k++) begin
      io_inp = 1'b1; tick(); io_inp = 1'b0;
      check("drain_fgi_clr", {7'd0, fgi}, 8'd0);
      tick();
      check("drain_fgi_set", {7'd0, fgi}, 8'd1);
      check("drain_order", inpr, 8'(k));
    end
    check("drain_rxv_done", {7'd0, dev_rx_valid}, 8'd0);
    io_inp = 1'b1; tick(); io_inp = 1'b0;
    tick();
    check("drain_empty_fgi", {7'd0, fgi}, 8'd0);
    check("drain_empty_rxr", {7'd0, dev_rx_ready}, 8'd1);

    out_data = 8'h5A; io_out = 1'b1; tick(); io_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("tx_valid", {7'd0, dev_tx_valid}, 8'd1);
      check("tx_data", dev_tx_data, 8'h5A);
      check("tx_fgo", {7'd0, fgo}, 8'd0);
      tick();
    end
    check("tx_nodrop", {7'd0, out_drop}, 8'd0);
    out_data = 8'h33; io_out = 1'b1; tick(); io_out = 1'b0;
    check("tx_drop", {7'd0, out_drop}, 8'd1);
    check("tx_data_kept", dev_tx_data, 8'h5A);
    dev_tx_ready = 1'b1; tick(); dev_tx_ready = 1'b0;
    check("tx_done_fgo", {7'd0, fgo}, 8'd1);
    check("tx_done_valid", {7'd0, dev_tx_valid}, 8'd0);
    tick();
    check("tx_drop_sticky", {7'd0, out_drop}, 8'd1);

    io_ion = 1'b1; tick(); io_ion = 1'b0;
    check("ion_ien", {7'd0, ien}, 8'd1);
    check("ion_irq_e1", {7'd0, irq}, 8'd0);
    tick();
    check("ion_irq_e2", {7'd0, irq}, 8'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("ack_irq", {7'd0, irq}, 8'd0);
    check("ack_ien", {7'd0, ien}, 8'd0);
    io_ion = 1'b1; io_iof = 1'b1; tick(); io_ion = 1'b0; io_iof = 1'b0;
    check("iof_prio", {7'd0, ien}, 8'd0);
    fetch_busy = 1'b1;
    io_ion = 1'b1; tick(); io_ion = 1'b0;
    tick(); tick();
    check("busy_ien", {7'd0, ien}, 8'd1);
    check("busy_irq", {7'd0, irq}, 8'd0);
    fetch_busy = 1'b0; tick();
    check("unbusy_irq", {7'd0, irq}, 8'd1);
    int_ack = 1'b1; io_ion = 1'b1; tick(); int_ack = 1'b0; io_ion = 1'b0;
    check("ack_prio_ien", {7'd0, ien}, 8'd0);
    check("ack_prio_irq", {7'd0, irq}, 8'd0);

    for (int k = 0; k < 3; k++) begin
      dev_rx_data = 8'h70 + 8'(k); dev_rx_valid = 1'b1;
      tick();
    end
    out_data = 8'hC3; io_out = 1'b1; tick(); io_out = 1'b0;
    check("pre_rst_fgi", {7'd0, fgi}, 8'd1);
    check("pre_rst_txv", {7'd0, dev_tx_valid}, 8'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_txv", {7'd0, dev_tx_valid}, 8'd0);
    check("mid_rst_fgo", {7'd0, fgo}, 8'd1);
    check("mid_rst_fgi", {7'd0, fgi}, 8'd0);
    check("mid_rst_inpr", inpr, 8'h00);
    check("mid_rst_outr", dev_tx_data, 8'h00);
    check("mid_rst_drop", {7'd0, out_drop}, 8'd0);
    tick(); tick();
    check("mid_rst_empty", {7'd0, fgi}, 8'd0);
    check("mid_rst_rxr", {7'd0, dev_rx_ready}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
